// File: rtl/sort_engine_run_loader.sv
// Leaf feeder for the merge tree: spreads one stream of sorted runs across
// LANE_CNT run buffers and releases them together once the batch is loaded or flushed.
module sort_engine_run_loader #(
  parameter int DWIDTH   = 8,
  parameter int LANE_CNT = 16,
  parameter int RUN_LEN  = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [DWIDTH-1:0]                 data_in_i,
  input  logic                              data_in_val_i,
  output logic                              data_in_ready_o,
  input  logic                              flush_i,
  output logic [LANE_CNT-1:0][DWIDTH-1:0]   data_out_o,
  output logic [LANE_CNT-1:0]               data_out_val_o,
  input  logic [LANE_CNT-1:0]               data_out_ready_i,
  output logic                              drain_o
);

  localparam int LW = $clog2(LANE_CNT);
  localparam int SW = $clog2(RUN_LEN);
  localparam int PW = SW + 1;
  localparam int WW = LW + SW;
  localparam int TOTAL = LANE_CNT * RUN_LEN;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                                       r_state;
  logic [WW-1:0]                                r_wcnt;
  logic [LANE_CNT-1:0][PW-1:0]                  r_cnt;
  logic [LANE_CNT-1:0][PW-1:0]                  r_rd;
  logic [LANE_CNT-1:0][RUN_LEN-1:0][DWIDTH-1:0] r_mem;

  logic                        w_in_xfer;
  logic                        w_last;
  logic                        w_flush;
  logic                        w_all_empty;
  logic [LW-1:0]               w_wlane;
  logic [SW-1:0]               w_wslot;
  logic [LANE_CNT-1:0]         w_val;
  logic [LANE_CNT-1:0]         w_pop;
  logic [LANE_CNT-1:0][PW-1:0] w_rd_nxt;

  // The write counter doubles as the lane/slot address of the next word.
  assign w_wlane   = r_wcnt[WW-1:SW];
  assign w_wslot   = r_wcnt[SW-1:0];
  assign w_in_xfer = (r_state == FILL) && data_in_val_i;
  assign w_last    = w_in_xfer && (r_wcnt == WW'(TOTAL - 1));
  assign w_flush   = (r_state == FILL) && flush_i && ((r_wcnt != '0) || w_in_xfer);

  assign data_in_ready_o = (r_state == FILL);
  assign drain_o         = (r_state == DRAIN);
  assign data_out_val_o  = w_val;

  always_comb begin
    w_val       = '0;
    w_pop       = '0;
    w_rd_nxt    = r_rd;
    w_all_empty = 1'b1;
    data_out_o  = '0;
    for (int l = 0; l < LANE_CNT; l++) begin
      w_val[l]      = (r_state == DRAIN) && (r_rd[l] < r_cnt[l]);
      w_pop[l]      = w_val[l] && data_out_ready_i[l];
      w_rd_nxt[l]   = r_rd[l] + {{(PW-1){1'b0}}, w_pop[l]};
      if (w_rd_nxt[l] < r_cnt[l]) w_all_empty = 1'b0;
      // A fully drained lane has rd=RUN_LEN; its low bits alias slot 0, masked by val=0.
      data_out_o[l] = r_mem[l][r_rd[l][SW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= FILL;
      r_wcnt  <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_mem   <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_xfer) begin
            r_mem[w_wlane][w_wslot] <= data_in_i;
            r_cnt[w_wlane]          <= r_cnt[w_wlane] + PW'(1);
            r_wcnt                  <= r_wcnt + WW'(1);
          end
          if (w_last || w_flush) r_state <= DRAIN;
        end
        DRAIN: begin
          r_rd <= w_rd_nxt;
          if (w_all_empty) begin
            r_state <= FILL;
            r_wcnt  <= '0;
            r_cnt   <= '0;
            r_rd    <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine_run_loader.sv
// Directed bench: a 4-lane/2-deep loader for the functional cases and a
// default-size loader for the mid-drain reset and full 64-word batch.
module tb_sort_engine_run_loader;

  logic clk;
  int   n_chk;
  int   n_pass;

  // Small instance: LANE_CNT=4, RUN_LEN=2
  logic             s_rst_n, s_dval, s_rdy, s_flush, s_drain;
  logic [7:0]       s_din;
  logic [3:0][7:0]  s_dout;
  logic [3:0]       s_oval, s_ordy;

  // Default instance: LANE_CNT=16, RUN_LEN=4
  logic             b_rst_n, b_dval, b_rdy, b_flush, b_drain;
  logic [7:0]       b_din;
  logic [15:0][7:0] b_dout;
  logic [15:0]      b_oval, b_ordy;

  sort_engine_run_loader #(.DWIDTH(8), .LANE_CNT(4), .RUN_LEN(2)) u_small (
    .clk_i(clk), .rst_n_i(s_rst_n), .data_in_i(s_din), .data_in_val_i(s_dval),
    .data_in_ready_o(s_rdy), .flush_i(s_flush), .data_out_o(s_dout),
    .data_out_val_o(s_oval), .data_out_ready_i(s_ordy), .drain_o(s_drain)
  );

  sort_engine_run_loader u_dut (
    .clk_i(clk), .rst_n_i(b_rst_n), .data_in_i(b_din), .data_in_val_i(b_dval),
    .data_in_ready_o(b_rdy), .flush_i(b_flush), .data_out_o(b_dout),
    .data_out_val_o(b_oval), .data_out_ready_i(b_ordy), .drain_o(b_drain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_send(input logic [7:0] v);
    s_din  = v;
    s_dval = 1'b1;
    tick();
    s_dval = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    s_rst_n = 1'b0; s_dval = 1'b0; s_flush = 1'b0; s_din = '0; s_ordy = '0;
    b_rst_n = 1'b0; b_dval = 1'b0; b_flush = 1'b0; b_din = '0; b_ordy = '0;
    tick(); tick();
    check("rst_rdy", s_rdy, 1'b1);
    check("rst_drain", s_drain, 1'b0);
    check("rst_val", s_oval, 4'b0000);
    check("rst_dout", s_dout, 32'h0);
    s_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();

    // Test 1: full load
    begin
      logic [7:0] vec [8] = '{8'd1, 8'd5, 8'd2, 8'd6, 8'd0, 8'd9, 8'd3, 8'd4};
      for (int i = 0; i < 8; i++) begin
        check("t1_rdy_fill", s_rdy, 1'b1);
        s_send(vec[i]);
      end
    end
    check("t1_rdy", s_rdy, 1'b0);
    check("t1_drain", s_drain, 1'b1);
    check("t1_val", s_oval, 4'b1111);
    check("t1_heads", s_dout, 32'h03_00_02_01);

    // Test 2: drain
    s_ordy = 4'b0100; tick(); s_ordy = '0;
    check("t2_headL2", s_dout[2], 8'd9);
    check("t2_val_a", s_oval, 4'b1111);
    check("t2_heads_a", s_dout, 32'h03_09_02_01);
    s_ordy = 4'b1111; tick();
    check("t2_val_b", s_oval, 4'b1011);
    check("t2_heads_b", {s_dout[3], s_dout[1], s_dout[0]}, 24'h04_06_05);
    check("t2_drain_b", s_drain, 1'b1);
    tick(); s_ordy = '0;
    check("t2_drain_end", s_drain, 1'b0);
    check("t2_rdy_end", s_rdy, 1'b1);
    check("t2_val_end", s_oval, 4'b0000);

    // Test 3: partial flush
    s_send(8'd7); s_send(8'd8); s_send(8'd9);
    check("t3_still_fill", s_drain, 1'b0);
    s_flush = 1'b1; tick(); s_flush = 1'b0;
    check("t3_drain", s_drain, 1'b1);
    check("t3_val", s_oval, 4'b0011);
    check("t3_L0", s_dout[0], 8'd7);
    check("t3_L1", s_dout[1], 8'd9);
    s_ordy = 4'b0001; tick();
    check("t3_L0b", s_dout[0], 8'd8);
    check("t3_val_b", s_oval, 4'b0011);
    s_ordy = 4'b0011; tick(); s_ordy = '0;
    check("t3_back_fill", s_drain, 1'b0);
    check("t3_rdy", s_rdy, 1'b1);

    // Test 4: flush edge cases
    s_flush = 1'b1; tick(); s_flush = 1'b0;
    check("t4_empty_flush", s_drain, 1'b0);
    check("t4_empty_rdy", s_rdy, 1'b1);
    s_flush = 1'b1; s_din = 8'd3; s_dval = 1'b1; tick();
    s_flush = 1'b0; s_dval = 1'b0;
    check("t4_drain", s_drain, 1'b1);
    check("t4_val", s_oval, 4'b0001);
    check("t4_L0", s_dout[0], 8'd3);
    s_flush = 1'b1; tick(); s_flush = 1'b0;
    check("t4_flush_in_drain", s_oval, 4'b0001);
    s_ordy = 4'b0001; tick(); s_ordy = '0;
    check("t4_back_fill", s_drain, 1'b0);

    // Test 5: backpressure with input offered during drain
    for (int i = 0; i < 8; i++) s_send(8'(10 + i));
    s_din = 8'd99; s_dval = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t5_val_hold", s_oval, 4'b1111);
      check("t5_heads_hold", s_dout, 32'h10_0E_0C_0A);
      check("t5_rdy_low", s_rdy, 1'b0);
    end
    s_ordy = 4'b1111; tick();
    check("t5_heads_2nd", s_dout, 32'h11_0F_0D_0B);
    tick(); s_ordy = '0; s_dval = 1'b0;
    check("t5_back_fill", s_drain, 1'b0);
    s_flush = 1'b1; s_din = 8'd42; s_dval = 1'b1; tick();
    s_flush = 1'b0; s_dval = 1'b0;
    check("t5_next_lane0_val", s_oval, 4'b0001);
    check("t5_next_lane0", s_dout[0], 8'd42);
    s_ordy = 4'b0001; tick(); s_ordy = '0;
    check("t5_done", s_drain, 1'b0);

    // Test 6: default parameters, reset mid-drain then full batch
    for (int k = 0; k < 20; k++) begin
      b_din = 8'(k); b_dval = 1'b1; tick();
    end
    b_dval = 1'b0;
    check("t6_fill20", b_drain, 1'b0);
    b_flush = 1'b1; tick(); b_flush = 1'b0;
    check("t6_drain20", b_drain, 1'b1);
    check("t6_val20", b_oval, 16'h001F);
    check("t6_L4head", b_dout[4], 8'd16);
    b_rst_n = 1'b0; #1;
    check("t6_rst_val", b_oval, 16'h0000);
    check("t6_rst_rdy", b_rdy, 1'b1);
    check("t6_rst_drain", b_drain, 1'b0);
    check("t6_rst_dout", b_dout, 128'h0);
    tick(); b_rst_n = 1'b1; tick();
    for (int k = 0; k < 64; k++) begin
      b_din = 8'(3 * k); b_dval = 1'b1; tick();
    end
    b_dval = 1'b0;
    check("t6_full_drain", b_drain, 1'b1);
    check("t6_full_rdy", b_rdy, 1'b0);
    for (int j = 0; j < 4; j++) begin
      logic [127:0] exp_heads;
      for (int l = 0; l < 16; l++) exp_heads[l*8 +: 8] = 8'(3 * (4 * l + j));
      check("t6_val", b_oval, 16'hFFFF);
      check("t6_heads", b_dout, exp_heads);
      b_ordy = 16'hFFFF; tick();
    end
    b_ordy = '0;
    check("t6_end_drain", b_drain, 1'b0);
    check("t6_end_rdy", b_rdy, 1'b1);
    check("t6_end_val", b_oval, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sort_engine_run_loader.md
Name: sort_engine_run_loader

Overview:
Leaf feeder for the merge tree. It takes a single input stream of pre-sorted runs and distributes the words into LANE_CNT per-lane run buffers, RUN_LEN words per lane. Lanes are released to the first merge tree stage only once the whole batch is loaded (or a flush is requested). This keeps every leaf valid from the first merge decision, because a merge stage treats an invalid input as "pass the other side". Its outputs connect directly to the first merge stage's data_in_i / data_in_val_i / data_in_ready_o.

Parameters:
DWIDTH, 8, data word width
LANE_CNT, 16, number of lanes (= IN_DATA_CNT of first merge stage); power of 2, >=2
RUN_LEN, 4, words per lane (one sorted run); power of 2, >=2

Ports:
clk_i  input  1  clock
rst_n_i  input  1  reset
data_in_i  input  DWIDTH  input word
data_in_val_i  input  1  input word valid
data_in_ready_o  output  1  loader accepts input word
flush_i  input  1  end partial batch, release loaded lanes
data_out_o  output  [LANE_CNT-1:0][DWIDTH-1:0]  head word per lane
data_out_val_o  output  LANE_CNT  lane head valid
data_out_ready_i  input  LANE_CNT  per-lane pop from merge stage
drain_o  output  1  high while in DRAIN state

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (async, rst_n_i=0): state=FILL; write count, all per-lane counts and read pointers = 0; storage = 0. Resulting outputs: data_out_o=0, data_out_val_o=0, drain_o=0, data_in_ready_o=1.
- A transfer occurs when val && ready, on both the input side and each output lane.
- FSM states: FILL, DRAIN. drain_o = (state==DRAIN).
- FILL:
  - data_in_ready_o=1; data_out_val_o=0.
  - Input word k of the batch (k = 0..LANE_CNT*RUN_LEN-1) is written to lane k/RUN_LEN, slot k%RUN_LEN. Lane count increments on write.
  - No ordering check is made on input data; upstream guarantees each run of RUN_LEN words is ascending.
- FILL->DRAIN, taking effect next cycle, on either:
  - transfer of word LANE_CNT*RUN_LEN-1; or
  - flush_i=1 with at least one word loaded, counting a word transferred in the same cycle. That word is stored and included in the batch.
- flush_i with zero words loaded and no transfer that cycle: ignored. flush_i in DRAIN: ignored.
- DRAIN:
  - data_in_ready_o=0.
  - data_out_o[l] = storage[l][rd_ptr[l]].
  - data_out_val_o[l] = (rd_ptr[l] < cnt[l]).
  - A pop on lane l increments rd_ptr[l]. Lanes pop independently; several may pop in the same cycle.
- DRAIN->FILL, taking effect next cycle, when every lane is empty after this cycle's pops. On entry to FILL, write count, cnt and rd_ptr are cleared.
- Partially loaded lanes: lanes with cnt=0 show val=0 for the whole DRAIN. A lane with cnt<RUN_LEN drains only its loaded words.
- data_out_val_o and data_out_o depend only on registers. There is no combinational path from data_out_ready_i to any output.
- data_out_ready_i on a lane with val=0 has no effect.
- Reset during DRAIN: the batch is discarded and the block restarts in FILL at lane 0, slot 0.
- Pointers are log2(RUN_LEN)+1 bits wide, so cnt=RUN_LEN is representable; no wrap within a batch.
- Total latency: last word accepted at cycle t -> all heads valid at t+1.

Test Plan:
(Tests 1-5 use LANE_CNT=4, RUN_LEN=2.)
1. Full load: send 1,5,2,6,0,9,3,4 back-to-back -> data_in_ready_o=0 and drain_o=1 the cycle after word 8; data_out_val_o=4'b1111; heads L0..L3 = 1,2,0,3.
2. Drain: from test 1, pop L2 -> head L2=9; pop all lanes until empty -> drain_o=0 and data_in_ready_o=1 the cycle after the final pop; data_out_val_o=0 in that cycle.
3. Partial flush: send 7,8,9 then flush_i in an idle cycle -> L0={7,8}, L1={9}, data_out_val_o=4'b0011. After popping L0 twice and L1 once -> return to FILL.
4. Flush edge cases: flush_i with zero words loaded -> stays FILL. flush_i in the same cycle as word 1 (value 3) -> DRAIN with L0 head=3, data_out_val_o=4'b0001.
5. Backpressure: in DRAIN, hold data_out_ready_i=0 for 5 cycles -> heads and vals stable. Present data_in_val_i=1 meanwhile -> no word accepted; the next batch still starts at lane 0.
6. Reset mid-DRAIN (default parameters, 20 words loaded) -> immediately data_out_val_o=0, data_in_ready_o=1; after release, a new full batch of 64 words loads and drains correctly.
